// File: rtl/spi_bus_arbiter_pkg.sv
// spi_bus_arbiter shared types: FSM state encoding, gap minimum, index width helper.
// Imported by spi_bus_arbiter and rr_arbiter.
package spi_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE,
    S_GAP
  } state_t;

  localparam int GAP_MIN = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Combinational round-robin grant.
// Search starts one past the last owner and wraps.
module rr_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  // first requester found after last owner wins
  always_comb begin
    logic [IW-1:0] k;
    k     = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = IW'((int'(last) + i) % NUM_REQ);
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between NUM_REQ requesters with round-robin grant.
// Define SPI_ARB_TIMEOUT_EN to enable the busy/done watchdog.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_BIT_WIDTH = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req,
  input  logic [NUM_REQ*DATA_BIT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                ack,
  output logic [DATA_BIT_WIDTH-1:0]         rx_data,
  output logic                              err,
  output logic [NUM_REQ-1:0]                cs,
  output logic                              spi_en,
  output logic                              spi_start,
  output logic [DATA_BIT_WIDTH-1:0]         spi_data_in,
  input  logic                              spi_busy,
  input  logic                              spi_valid,
  input  logic [DATA_BIT_WIDTH-1:0]         spi_data_out
);

  localparam int IW  = idx_w(NUM_REQ);
  localparam int DW  = DATA_BIT_WIDTH;
  localparam int GE  = (GAP_CYCLES < GAP_MIN) ? GAP_MIN : GAP_CYCLES;
  localparam int GW  = $clog2(GE + 1);

  state_t            state, state_n;
  logic [IW-1:0]     owner;
  logic [DW-1:0]     word;
  logic              start_cnt;
  logic [GW-1:0]     gap_cnt;
  logic              to_hit;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_any;
  logic [DW-1:0]     words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DW +: DW];
  end

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_rr (
    .req  (req),
    .last (owner),
    .grant(grant),
    .idx  (grant_idx),
    .any  (grant_any)
  );

  wire waiting = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  logic          timed_out;

  assign to_hit = waiting && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  // watchdog counts cycles spent waiting on the master
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timed_out <= 1'b0;
    end else begin
      wd_cnt <= waiting ? wd_cnt + 1'b1 : '0;
      if (state_n == S_CAPTURE && state != S_CAPTURE)
        timed_out <= to_hit;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:      if (|req) state_n = S_ARB;
      S_ARB:       state_n = grant_any ? S_START : S_IDLE;
      S_START:     if (start_cnt) state_n = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (to_hit)        state_n = S_CAPTURE;
        else if (spi_busy) state_n = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (to_hit)                      state_n = S_CAPTURE;
        else if (!spi_busy && spi_valid) state_n = S_CAPTURE;
      end
      S_CAPTURE:   state_n = S_GAP;
      S_GAP:       if (gap_cnt == GW'(GE - 1)) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // owner/word latch, counters, rx capture, master enable
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= IW'(NUM_REQ - 1);
      word      <= '0;
      rx_data   <= '0;
      start_cnt <= 1'b0;
      gap_cnt   <= '0;
      spi_en    <= 1'b0;
    end else begin
      spi_en    <= !to_hit;
      start_cnt <= (state == S_START) ? ~start_cnt : 1'b0;
      gap_cnt   <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      if (state == S_ARB && grant_any) begin
        owner <= grant_idx;
        word  <= words[grant_idx];
      end
      if (state_n == S_CAPTURE && state != S_CAPTURE)
        rx_data <= to_hit ? '0 : spi_data_out;
    end
  end

  assign spi_data_in = word;

  // outputs decoded from state
  always_comb begin
    spi_start = 1'b0;
    cs        = '0;
    ack       = '0;
    err       = 1'b0;
    unique case (state)
      S_ARB:   cs = grant;
      S_START: begin
        spi_start = 1'b1;
        cs[owner] = 1'b1;
      end
      S_WAIT_BUSY,
      S_WAIT_DONE: cs[owner] = 1'b1;
      S_CAPTURE: begin
        cs[owner]  = 1'b1;
        ack[owner] = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
        err = timed_out;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a loopback SPI master model.
// Timeout case runs when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_bus_arbiter;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int GAP = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      ack;
  logic [DW-1:0]     rx_data;
  logic              err;
  logic [N-1:0]      cs;
  logic              spi_en;
  logic              spi_start;
  logic [DW-1:0]     spi_data_in;
  logic              spi_busy = 1'b0;
  logic              spi_valid = 1'b0;
  logic [DW-1:0]     spi_data_out = '0;

  spi_bus_arbiter #(
    .NUM_REQ       (N),
    .DATA_BIT_WIDTH(DW),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .rx_data     (rx_data),
    .err         (err),
    .cs          (cs),
    .spi_en      (spi_en),
    .spi_start   (spi_start),
    .spi_data_in (spi_data_in),
    .spi_busy    (spi_busy),
    .spi_valid   (spi_valid),
    .spi_data_out(spi_data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // loopback master: busy 2 cycles after START edge, 9 busy cycles
  logic          stuck = 1'b0;
  logic          st_q = 1'b0;
  logic          pend = 1'b0;
  logic [2:0]    dly = '0;
  logic [3:0]    bcnt = '0;
  logic [DW-1:0] mword = '0;

  always_ff @(posedge clk) begin
    if (!spi_en) begin
      st_q      <= 1'b0;
      pend      <= 1'b0;
      spi_busy  <= 1'b0;
      spi_valid <= 1'b0;
      dly       <= '0;
      bcnt      <= '0;
    end else begin
      st_q <= spi_start;
      if (spi_start && !st_q && !stuck) begin
        pend      <= 1'b1;
        dly       <= 3'd2;
        mword     <= spi_data_in;
        spi_valid <= 1'b0;
      end else if (pend) begin
        if (dly == 0) begin
          pend     <= 1'b0;
          spi_busy <= 1'b1;
          bcnt     <= 4'd8;
        end else begin
          dly <= dly - 1'b1;
        end
      end else if (spi_busy) begin
        if (bcnt == 0) begin
          spi_busy     <= 1'b0;
          spi_valid    <= 1'b1;
          spi_data_out <= mword;
        end else begin
          bcnt <= bcnt - 1'b1;
        end
      end
    end
  end

  // start pulse shape, busy response and ack spacing monitors
  int   hi_run = 0;
  int   lo_run = 0;
  int   starts = 0;
  int   busy_rises = 0;
  logic busy_prev = 1'b0;
  int   prev_ack = -1000;

  always @(negedge clk) begin
    if (spi_start) begin
      if (hi_run == 0) begin
        starts++;
        check("start_low_before", 32'(lo_run >= 2), 1);
      end
      hi_run++;
      lo_run = 0;
    end else begin
      if (hi_run != 0) check("start_width", hi_run, 2);
      hi_run = 0;
      lo_run++;
    end
    if (spi_busy && !busy_prev) busy_rises++;
    busy_prev = spi_busy;
    if (ack != 0) begin
      check("ack_onehot", 32'($onehot(ack)), 1);
      check("ack_spacing", 32'((cyc - prev_ack) > GAP), 1);
      prev_ack = cyc;
    end
  end

  typedef struct {
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [N-1:0]    exp_ack;
    logic [DW-1:0]   exp_rx;
  } vec_t;

  vec_t tbl [6];

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ack(input string name, input int budget,
                          output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_no_ack"}, 0, 1);
  endtask

  task automatic apply(input string name, input logic [N-1:0] r,
                       input logic [N*DW-1:0] d, input logic [N-1:0] ea,
                       input logic [DW-1:0] erx);
    int   seen;
    logic ok;
    seen     = 0;
    ok       = 1'b0;
    req_data = d;
    req      = r;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        ok = 1'b1;
        break;
      end
      if (cs != 0) seen++;
      if (seen == 2) begin
        check({name, "_cs"}, 32'(cs), 32'(ea));
        req_data = ~d;
      end
    end
    if (!ok) check({name, "_no_ack"}, 0, 1);
    check({name, "_ack"}, 32'(ack), 32'(ea));
    check({name, "_rx"}, 32'(rx_data), 32'(erx));
    check({name, "_err"}, 32'(err), 0);
    req = '0;
    @(negedge clk);
    check({name, "_cs_off"}, 32'(cs), 0);
    repeat (GAP + 2) @(negedge clk);
  endtask

  initial begin
    logic ok;
    logic [N-1:0] ea;
    int   extra;

    tbl[0] = '{4'b0001, {16'h1111, 16'h2222, 16'h3333, 16'hA5C3}, 4'b0001, 16'hA5C3};
    tbl[1] = '{4'b0100, {16'hD00D, 16'hBEEF, 16'h0F0F, 16'h0000}, 4'b0100, 16'hBEEF};
    tbl[2] = '{4'b1010, {16'h8001, 16'h7777, 16'h5A5A, 16'h6666}, 4'b1000, 16'h8001};
    tbl[3] = '{4'b1010, {16'hFFFF, 16'h0000, 16'h1234, 16'h9999}, 4'b0010, 16'h1234};
    tbl[4] = '{4'b1111, {16'hAAAA, 16'h5555, 16'hCCCC, 16'h3333}, 4'b0100, 16'h5555};
    tbl[5] = '{4'b1001, {16'h0001, 16'h0002, 16'h0003, 16'h0004}, 4'b1000, 16'h0001};

    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cs", 32'(cs), 0);
    check("rst_start", 32'(spi_start), 0);
    check("rst_en", 32'(spi_en), 0);
    check("rst_rx", 32'(rx_data), 0);
    rst = 1'b0;
    @(negedge clk);
    check("en_after_rst", 32'(spi_en), 1);

    for (int v = 0; v < 6; v++)
      apply($sformatf("vec%0d", v), tbl[v].req, tbl[v].data,
            tbl[v].exp_ack, tbl[v].exp_rx);

    // requester drops req mid-transfer, ack still comes
    req_data = {16'h0, 16'h0, 16'h0B0B, 16'h0};
    req = 4'b0010;
    for (int i = 0; i < 50 && cs == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    req = '0;
    wait_ack("drop", 200, ok);
    check("drop_ack", 32'(ack), 32'(4'b0010));
    check("drop_rx", 32'(rx_data), 32'h0B0B);
    repeat (GAP + 2) @(negedge clk);

    // reset while waiting for the master to finish
    req_data = {16'h0, 16'h0, 16'h0, 16'h7E7E};
    req = 4'b0001;
    for (int i = 0; i < 100 && !spi_busy; i++) @(negedge clk);
    check("mid_busy_seen", 32'(spi_busy), 1);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("mid_cs", 32'(cs), 0);
    check("mid_en", 32'(spi_en), 0);
    check("mid_ack", 32'(ack), 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (ack != 0) extra++;
    end
    check("mid_no_ack", extra, 0);
    apply("after_rst", 4'b0010, {16'h0, 16'h0, 16'hC0DE, 16'h0},
          4'b0010, 16'hC0DE);

    // full contention from reset: 0,1,2,3,0
    do_reset();
    req_data = {16'h3003, 16'h2002, 16'h1001, 16'h0000};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack("cont", 300, ok);
      ea = '0;
      ea[k % 4] = 1'b1;
      check($sformatf("cont%0d_ack", k), 32'(ack), 32'(ea));
      check($sformatf("cont%0d_rx", k), 32'(rx_data), 32'((k % 4) * 16'h1001));
    end
    req = '0;
    repeat (GAP + 4) @(negedge clk);

    // fairness: req0 re-asserted after each ack, req2 held
    do_reset();
    req_data = {16'h0, 16'h2222, 16'h0, 16'h1111};
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      wait_ack("fair", 300, ok);
      ea = (k % 2 == 0) ? 4'b0001 : 4'b0100;
      check($sformatf("fair%0d_ack", k), 32'(ack), 32'(ea));
      if (ack[0]) begin
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0101;
      end
    end
    req = '0;
    repeat (GAP + 4) @(negedge clk);

    check("busy_per_start", busy_rises, starts);

`ifdef SPI_ARB_TIMEOUT_EN
    stuck = 1'b1;
    req_data = {16'h0, 16'h0, 16'h0, 16'hFACE};
    req = 4'b0001;
    wait_ack("to", 400, ok);
    check("to_ack", 32'(ack), 32'(4'b0001));
    check("to_err", 32'(err), 1);
    check("to_rx", 32'(rx_data), 0);
    check("to_en", 32'(spi_en), 0);
    req = '0;
    stuck = 1'b0;
    repeat (GAP + 2) @(negedge clk);
    apply("post_to", 4'b0100, {16'h0, 16'h4321, 16'h0, 16'h0},
          4'b0100, 16'h4321);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: sim time %0t limit reached", $time);
    $fatal(1);
  end

endmodule
